// File: rtl/fir_pkg.sv
// Shared widths, types, FSM states and output rounding for the polyphase FIR interpolator.
// Optional macro FIR_INTERP_SAT_EN: saturate the rounded result instead of wrapping it.
package fir_pkg;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 9;
    localparam int PROD_W    = DATA_W + COEF_W;
    localparam int ACC_MAX_W = 40;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    // Round half-up at the binary point, then narrow to sample width.
    function automatic sample_t round_narrow(input logic signed [ACC_MAX_W-1:0] acc,
                                             input int unsigned frac);
        logic signed [ACC_MAX_W-1:0] rnd;
        logic signed [ACC_MAX_W-1:0] sh;
        sample_t                     res;
`ifdef FIR_INTERP_SAT_EN
        logic signed [ACC_MAX_W-1:0] hi;
        logic signed [ACC_MAX_W-1:0] lo;
`endif
        rnd = acc;
        if (frac > 0) begin
            rnd = acc + (ACC_MAX_W'(1) << (frac - 1));
        end
        sh  = rnd >>> frac;
        res = sample_t'(sh);
`ifdef FIR_INTERP_SAT_EN
        hi = ACC_MAX_W'((2 ** (DATA_W - 1)) - 1);
        lo = ~hi;
        if (sh > hi) begin
            res = sample_t'(hi);
        end else if (sh < lo) begin
            res = sample_t'(lo);
        end
`endif
        return res;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply feeding a registered accumulator with synchronous clear.
// The next-accumulator sum is also exported so the caller can capture the final total directly.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int A_W   = DATA_W,
    parameter int B_W   = COEF_W,
    parameter int ACC_W = PROD_W + 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc_sum
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    always_comb begin
        prod    = P_W'(a) * P_W'(b);
        acc_sum = acc_q + ACC_W'(prod);
        acc_d   = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fir_interp_polyphase.sv
// Polyphase FIR interpolator: one input sample yields L outputs, one shared MAC, runtime coefficients.
// Optional macro FIR_INTERP_SAT_EN (in fir_pkg) selects saturating output narrowing.
module fir_interp_polyphase
    import fir_pkg::*;
#(
    parameter int DATA_W    = fir_pkg::DATA_W,
    parameter int COEF_W    = fir_pkg::COEF_W,
    parameter int L         = 2,
    parameter int NTAPS     = 16,
    parameter int COEF_FRAC = 8
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]        coef_din,
    output logic                     busy
);

    localparam int TPP   = NTAPS / L;
    localparam int TAP_W = (TPP > 1) ? $clog2(TPP) : 1;
    localparam int PH_W  = $clog2(L);
    localparam int AW    = $clog2(NTAPS);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(TPP);

    state_t                           state_q, state_d;
    logic [PH_W-1:0]                  phase_q, phase_d;
    logic [TAP_W-1:0]                 tap_q, tap_d;
    logic [DATA_W-1:0]                out_data_q, out_data_d;
    logic                             out_valid_q, out_valid_d;
    logic [TPP-1:0][DATA_W-1:0]       x_q, x_d;
    logic [NTAPS-1:0][COEF_W-1:0]     coef_q, coef_d;

    logic                             accept;
    logic                             coef_wr;
    logic                             mac_clr;
    logic                             mac_en;
    logic [AW-1:0]                    coef_idx;
    logic signed [ACC_W-1:0]          acc_sum;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    assign coef_wr  = coef_we && (state_q == IDLE) && ({1'b0, coef_addr} < (AW + 1)'(NTAPS));
    assign coef_idx = AW'(int'(tap_q) * L + int'(phase_q));

    fir_mac_unit #(
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .clr     (mac_clr),
        .en      (mac_en),
        .a       ($signed(x_q[tap_q])),
        .b       ($signed(coef_q[coef_idx])),
        .acc_sum (acc_sum)
    );

    always_comb begin
        coef_d = coef_q;
        if (coef_wr) begin
            coef_d[coef_addr] = coef_din;
        end
        x_d = x_q;
        if (accept) begin
            x_d = {x_q[TPP-2:0], in_data};
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        tap_d       = tap_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        accept      = 1'b0;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    phase_d = '0;
                    tap_d   = '0;
                    mac_clr = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (tap_q == TAP_W'(TPP - 1)) begin
                    // acc_sum already includes the last tap's product, so no drain cycle is needed.
                    tap_d       = '0;
                    out_data_d  = round_narrow({{(ACC_MAX_W - ACC_W){acc_sum[ACC_W-1]}}, acc_sum},
                                               COEF_FRAC);
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (phase_q != PH_W'(L - 1)) begin
                        phase_d = phase_q + PH_W'(1);
                        mac_clr = 1'b1;
                        state_d = MAC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            tap_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            coef_q      <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            tap_q       <= tap_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
            coef_q      <= coef_d;
        end
    end

endmodule

// File: doc/fir_interp_polyphase.md
Name: fir_interp_polyphase

Overview:
- Polyphase FIR interpolator (upsample by L) for the synthesis side of the multirate filterbank; the counterpart of the transposed-FIR decimating analysis path.
- Accepts one 16-bit signed sample per handshake and emits L filtered 16-bit samples.
- Uses one time-multiplexed 16s x 9s multiplier (25-bit product) and an accumulator.
- Coefficients are runtime-writable through a simple write port.

Parameters:
- DATA_W, 16, input/output sample width (signed)
- COEF_W, 9, coefficient width (signed)
- L, 2, interpolation factor (power of 2, >=2)
- NTAPS, 16, total prototype taps (multiple of L); TPP = NTAPS/L taps per phase
- COEF_FRAC, 8, coefficient fractional bits (output right-shift)

Ports:
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst  in  1  synchronous active-high reset
- in_data  in  DATA_W  input sample
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- out_data  out  DATA_W  interpolated output sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(NTAPS)  coefficient index k
- coef_din  in  COEF_W  coefficient value h[k]
- busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Clock and reset: single clock ap_clk; reset ap_rst is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, FSM=IDLE, phase=0, tap=0, accumulator=0. The delay line x[0..TPP-1] and all coefficients clear to 0.
- Reset mid-operation aborts the sample in progress. No partial output is ever presented.
- Math: y[nL+p] = sum over j=0..TPP-1 of h[p+jL]*x[n-j], for p=0..L-1.
  - Product is DATA_W+COEF_W = 25 bits; accumulator is 25+clog2(TPP) bits.
  - Result = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, an arithmetic shift with round-half-up.
  - Result is then narrowed to DATA_W (see optional feature).
- FSM:
  - IDLE: in_ready=1. On in_valid&in_ready, shift the delay line (x[0]<=in_data, x[j]<=x[j-1]), set phase=0, tap=0, acc=0, then go to MAC.
  - MAC: one multiply-accumulate per cycle using tap j=tap. After TPP cycles, register the narrowed result into out_data, set out_valid=1, then go to OUT.
  - OUT: hold out_data stable while out_valid&!out_ready. On out_ready:
    - if phase<L-1: phase++, acc=0, go to MAC;
    - otherwise: out_valid=0, go to IDLE.
- Latency: sample accepted at cycle 0 gives the first out_valid at cycle TPP+1. With out_ready tied high, throughput is one input per L*(TPP+1)+1 cycles.
- in_ready is low in MAC and OUT, with no input buffering. in_valid while busy is simply not accepted.
- Coefficient writes take effect only when busy=0; a write while busy=1 is dropped. A write in the same cycle as an input accept is applied, and the new value is visible from the first MAC cycle.
- coef_addr >= NTAPS is ignored.

Optional Feature:
- Macro: FIR_INTERP_SAT_EN.
- Defined: the rounded result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: two's-complement wrap, i.e. the low DATA_W bits are kept.

Decomposition:
- Shared package fir_pkg holds:
  - DATA_W/COEF_W defaults and the product width constant (PROD_W=25);
  - sample_t and coef_t signed typedefs;
  - the FSM state enum (IDLE, MAC, OUT);
  - the round/narrow function.
- One natural sub-module: fir_mac_unit, a registered 16s x 9s multiply plus accumulate with a clear input. The top keeps the FSM, delay line and coefficient bank.

Test Plan:
- Impulse response:
  - Stimulus: write h[k]=k+1 for k=0..15; feed 256 followed by seven 0s; out_ready=1.
  - Expect: outputs 1,2,3,...,16 in order, then 0s.
- Latency:
  - Stimulus: a single accepted sample at cycle 0, out_ready=1.
  - Expect: out_valid first high at cycle 9 (TPP=8), in_ready low from cycle 1 until IDLE is re-entered.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles while out_valid=1.
  - Expect: out_data stable, in_ready=0, phase unchanged; the next output follows the release.
- Saturation:
  - Stimulus: all h=255; feed eight samples of 32767.
  - Expect: the 8th sample's outputs are 32767 with FIR_INTERP_SAT_EN, and -1032 (wrap) without it.
- Coefficient write while busy:
  - Stimulus: coef_we during MAC.
  - Expect: write dropped; a readback impulse shows the old value.
- Mid-operation reset:
  - Stimulus: assert ap_rst during MAC.
  - Expect: next cycle out_valid=0, in_ready=1, busy=0; a subsequent impulse with no coefficient rewrite yields all-zero outputs.
